// File: rtl/test_seq_pkg.sv
// Purpose: shared types and pattern codes for the test pattern sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none.
package test_seq_pkg;

    localparam int NUM_PATTERNS = 4;

    // Pattern codes understood by test_signal_gen.pattern_sel
    localparam logic [1:0] PAT_INC    = 2'b00;
    localparam logic [1:0] PAT_SQUARE = 2'b01;
    localparam logic [1:0] PAT_LFSR   = 2'b10;
    localparam logic [1:0] PAT_AA55   = 2'b11;

    // GAP is only reachable when the inter-step gap feature is compiled in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    // Index of the lowest set bit; 0 when the mask is empty
    function automatic logic [1:0] lowest_set(input logic [NUM_PATTERNS-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_step_pick.sv
// Purpose: finds the first enabled step and the next enabled step above the current one.
// Latency: purely combinational.
// Backpressure: none.
module seq_step_pick
    import test_seq_pkg::*;
(
    input  logic [NUM_PATTERNS-1:0] mask,
    input  logic [1:0]              cur_step,
    output logic [1:0]              next_step,
    output logic                    wrap,
    output logic [1:0]              first_step
);

    logic [NUM_PATTERNS-1:0] higher;

    // Keep only mask bits strictly above the current step; fall back to the first bit on wrap
    always_comb begin
        higher = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            higher[i] = mask[i] && (2'(i) > cur_step);
        end
        first_step = lowest_set(mask);
        wrap       = (higher == '0);
        next_step  = wrap ? first_step : lowest_set(higher);
    end

endmodule

// File: rtl/test_pattern_sequencer.sv
// Purpose: steps test_signal_gen through masked patterns with per-step dwell, loop and sync pulse (SEQ_GAP_EN adds one idle cycle between steps).
// Latency: all outputs registered; a start sampled at edge N is visible from edge N.
// Backpressure: none; start while busy is ignored, stop aborts at the next edge.
module test_pattern_sequencer
    import test_seq_pkg::*;
#(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic [3:0]             step_mask,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    output logic                   gen_enable,
    output logic [1:0]             gen_pattern_sel,
    output logic                   seq_sync,
    output logic                   busy,
    output logic                   done
);

    seq_state_e             state_q, state_d;
    logic [1:0]             step_q, step_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             mask_q, mask_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   en_q, en_d;
    logic [1:0]             sel_q, sel_d;
    logic                   sync_q, sync_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [3:0] pick_mask;
    logic [1:0] next_step;
    logic       wrap;
    logic [1:0] first_step;

    // Dwell 0 behaves like dwell 1; the counter counts dwell-1 down to 0
    function automatic logic [DWELL_WIDTH-1:0] load_of(input logic [DWELL_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // While idle the picker looks at the live mask (for start), otherwise at the latched one
    assign pick_mask = (state_q == IDLE) ? step_mask : mask_q;

    seq_step_pick u_pick (
        .mask       (pick_mask),
        .cur_step   (step_q),
        .next_step  (next_step),
        .wrap       (wrap),
        .first_step (first_step)
    );

    // Next-state and next-output logic; outputs default to idle, pattern select holds
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        en_d    = 1'b0;
        sel_d   = sel_q;
        sync_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (step_mask != 4'b0000)) begin
                        mask_d  = step_mask;
                        dwell_d = dwell_cycles;
                        step_d  = first_step;
                        cnt_d   = load_of(dwell_cycles);
                        state_d = RUN;
                        en_d    = 1'b1;
                        sel_d   = first_step;
                        sync_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - 1'b1;
                        en_d   = 1'b1;
                        sel_d  = step_q;
                        busy_d = 1'b1;
                    end else if (!wrap || loop_en) begin
                        step_d = next_step;
                        sel_d  = next_step;
                        busy_d = 1'b1;
`ifdef SEQ_GAP_EN
                        state_d = GAP;
`else
                        state_d = RUN;
                        cnt_d   = load_of(dwell_q);
                        en_d    = 1'b1;
                        sync_d  = 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef SEQ_GAP_EN
                GAP: begin
                    state_d = RUN;
                    cnt_d   = load_of(dwell_q);
                    en_d    = 1'b1;
                    sel_d   = step_q;
                    sync_d  = 1'b1;
                    busy_d  = 1'b1;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 2'b00;
            cnt_q   <= '0;
            mask_q  <= 4'b0000;
            dwell_q <= '0;
            en_q    <= 1'b0;
            sel_q   <= PAT_INC;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            sync_q  <= sync_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gen_enable      = en_q;
    assign gen_pattern_sel = sel_q;
    assign seq_sync        = sync_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Purpose: directed scoreboard bench for test_pattern_sequencer (gap cases follow SEQ_GAP_EN).
// Latency: expects outputs to reflect inputs sampled at the same rising edge.
// Backpressure: n/a.
module tb_test_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [3:0]  step_mask;
    logic [15:0] dwell_cycles;
    logic        gen_enable;
    logic [1:0]  gen_pattern_sel;
    logic        seq_sync;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic       sync;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t       exp_q[$];
    logic [1:0] last_sel;
    string      tag;
    int         n_cmp  = 0;
    int         n_fail = 0;

    test_pattern_sequencer #(.DWELL_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .loop_en         (loop_en),
        .step_mask       (step_mask),
        .dwell_cycles    (dwell_cycles),
        .gen_enable      (gen_enable),
        .gen_pattern_sel (gen_pattern_sel),
        .seq_sync        (seq_sync),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic en, input logic [1:0] sel, input logic sync,
                        input logic bsy, input logic dn);
        obs_t e;
        e.en = en; e.sel = sel; e.sync = sync; e.busy = bsy; e.done = dn;
        exp_q.push_back(e);
    endtask

    // One full step: enable high for max(dwell,1) cycles, sync on the first
    task automatic push_step(input logic [1:0] sel, input int dwell);
        int d;
        d = (dwell < 1) ? 1 : dwell;
        for (int i = 0; i < d; i++) push(1'b1, sel, (i == 0), 1'b1, 1'b0);
        last_sel = sel;
    endtask

    // Inter-step gap cycle: only present when the gap feature is built in
    task automatic push_gap(input logic [1:0] next_sel);
`ifdef SEQ_GAP_EN
        push(1'b0, next_sel, 1'b0, 1'b1, 1'b0);
        last_sel = next_sel;
`else
        last_sel = last_sel;
`endif
    endtask

    task automatic push_idle(input int n, input logic first_done);
        for (int i = 0; i < n; i++) push(1'b0, last_sel, 1'b0, 1'b0, (i == 0) && first_done);
    endtask

    // Advance one edge, release single-cycle pulses, compare against the next expectation
    task automatic cyc();
        obs_t got, e;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        got = '{en: gen_enable, sel: gen_pattern_sel, sync: seq_sync, busy: busy, done: done};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, got %b required an entry", tag, got);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s: got en/sel/sync/busy/done=%b required %b", tag, got, e);
            end
        end
    endtask

    task automatic drain_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            cyc();
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        step_mask = 4'b0000; dwell_cycles = 16'd0;
        last_sel = 2'b00;

        // Reset values
        tag = "reset";
        push_idle(2, 1'b0);
        drain();
        rst = 1'b0;
        push_idle(1, 1'b0);
        drain();

        // Full mask, dwell 5, no loop
        tag = "full_seq";
        step_mask = 4'b1111; dwell_cycles = 16'd5; loop_en = 1'b0;
        start = 1'b1;
        push_step(2'b00, 5); push_gap(2'b01);
        push_step(2'b01, 5); push_gap(2'b10);
        push_step(2'b10, 5); push_gap(2'b11);
        push_step(2'b11, 5);
        push_idle(3, 1'b1);
        drain();

        // Loop over bits 1 and 3, then stop
        tag = "loop_stop";
        step_mask = 4'b1010; dwell_cycles = 16'd3; loop_en = 1'b1;
        start = 1'b1;
        push_step(2'b01, 3); push_gap(2'b11);
        push_step(2'b11, 3); push_gap(2'b01);
        push_step(2'b01, 3); push_gap(2'b11);
        push_step(2'b11, 3);
        drain();
        stop = 1'b1;
        push_idle(3, 1'b0);
        drain();
        loop_en = 1'b0;

        // Empty mask start is ignored
        tag = "mask_zero";
        step_mask = 4'b0000; dwell_cycles = 16'd4;
        start = 1'b1;
        push_idle(3, 1'b0);
        drain();

        // Dwell 0 acts as 1
        tag = "dwell_zero";
        step_mask = 4'b0001; dwell_cycles = 16'd0;
        start = 1'b1;
        push_step(2'b00, 0);
        push_idle(2, 1'b1);
        drain();

        // Single-bit mask with loop repeats the step with fresh sync pulses
        tag = "single_loop";
        step_mask = 4'b0100; dwell_cycles = 16'd2; loop_en = 1'b1;
        start = 1'b1;
        push_step(2'b10, 2); push_gap(2'b10);
        push_step(2'b10, 2);
        drain();
        stop = 1'b1;
        loop_en = 1'b0;
        push_idle(2, 1'b0);
        drain();

        // Start and stop together: stop wins
        tag = "start_stop";
        step_mask = 4'b1111; dwell_cycles = 16'd2;
        start = 1'b1; stop = 1'b1;
        push_idle(3, 1'b0);
        drain();

        // Start while busy with different config does not disturb timing
        tag = "start_busy";
        step_mask = 4'b0110; dwell_cycles = 16'd3;
        start = 1'b1;
        push_step(2'b01, 3); push_gap(2'b10);
        push_step(2'b10, 3);
        push_idle(2, 1'b1);
        drain_n(2);
        step_mask = 4'b1111; dwell_cycles = 16'd7;
        start = 1'b1;
        drain();

        // Reset mid-step aborts with reset-state outputs
        tag = "reset_mid";
        step_mask = 4'b1111; dwell_cycles = 16'd8;
        start = 1'b1;
        push_step(2'b00, 8); push_gap(2'b01);
        push(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
`ifndef SEQ_GAP_EN
        push(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
`endif
        drain();
        rst = 1'b1;
        last_sel = 2'b00;
        push_idle(1, 1'b0);
        drain();
        rst = 1'b0;
        push_idle(2, 1'b0);
        drain();

`ifdef SEQ_GAP_EN
        // Gap between two steps: enable 1111 0 1111, busy for 9 cycles
        tag = "gap";
        step_mask = 4'b0011; dwell_cycles = 16'd4;
        start = 1'b1;
        push_step(2'b00, 4); push_gap(2'b01);
        push_step(2'b01, 4);
        push_idle(2, 1'b1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
